// File: rtl/riscado_pkg.sv
// Shared types for the ROM arbiter: owner state encoding, grant vector, range helper.
package riscado_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = WORD_W - 2;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic data;
    logic fetch;
  } gnt_t;

  // Word index at or beyond the ROM depth has no backing storage.
  function automatic logic rom_out_of_range(input logic [IDX_W-1:0] idx,
                                            input int unsigned len);
    return {2'b00, idx} >= len;
  endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Two-request picker: grants a lone requester, otherwise the preferred one.
module rom_arb_pick
  import riscado_pkg::*;
(
  input  logic req_fetch_i,
  input  logic req_data_i,
  input  logic prefer_fetch_i,
  output gnt_t gnt_c_o
);

  always_comb begin
    gnt_c_o = '0;
    if (req_fetch_i && (!req_data_i || prefer_fetch_i)) begin
      gnt_c_o.fetch = 1'b1;
    end else if (req_data_i) begin
      gnt_c_o.data = 1'b1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-output ROM between a fetch port and a data port.
// Define ROM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority per FETCH_PRIO.
module rom_arbiter
  import riscado_pkg::*;
#(
  parameter int unsigned LEN        = 10000,
  parameter int unsigned FETCH_PRIO = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iReq,
  input  logic [WORD_W-1:0] iAddr,
  output logic              iGnt,
  output logic              iValid,
  output logic [WORD_W-1:0] iData,
  output logic              iErr,
  input  logic              dReq,
  input  logic [WORD_W-1:0] dAddr,
  output logic              dGnt,
  output logic              dValid,
  output logic [WORD_W-1:0] dData,
  output logic              dErr,
  output logic              memEnable,
  output logic [WORD_W-1:0] memAddress,
  input  logic [WORD_W-1:0] memDataOut
);

  owner_e            owner_q, owner_d;
  logic              err_q, err_d;
  logic              prefer_fetch;
  gnt_t              pick;
  logic              any_gnt;
  logic [WORD_W-1:0] win_addr;
  logic              win_oor;

`ifdef ROM_ARB_RR_EN
  logic ptr_q, ptr_d;
  logic contended;

  assign contended    = iReq & dReq & resetn;
  assign prefer_fetch = ptr_q;

  // Pointer moves away from the winner only when both ports competed.
  always_comb begin
    ptr_d = ptr_q;
    if (contended) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign prefer_fetch = (FETCH_PRIO != 0);
`endif

  rom_arb_pick u_pick (
    .req_fetch_i    (iReq),
    .req_data_i     (dReq),
    .prefer_fetch_i (prefer_fetch),
    .gnt_c_o        (pick)
  );

  // Grants are suppressed while reset is asserted.
  assign iGnt     = pick.fetch & resetn;
  assign dGnt     = pick.data & resetn;
  assign any_gnt  = iGnt | dGnt;
  assign win_addr = iGnt ? iAddr : dAddr;
  assign win_oor  = rom_out_of_range(win_addr[WORD_W-1:2], LEN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    owner_d    = OWN_NONE;
    err_d      = 1'b0;
    memEnable  = 1'b0;
    memAddress = '0;
    if (iGnt) begin
      owner_d = OWN_FETCH;
    end else if (dGnt) begin
      owner_d = OWN_DATA;
    end
    if (any_gnt) begin
      err_d      = win_oor;
      memEnable  = ~win_oor;
      memAddress = win_addr;
    end
  end

  // Responses are decoded from the owner; an out-of-range read returns zero data.
  always_comb begin
    iValid = (owner_q == OWN_FETCH);
    dValid = (owner_q == OWN_DATA);
    iErr   = iValid & err_q;
    dErr   = dValid & err_q;
    iData  = '0;
    dData  = '0;
    if (iValid && !err_q) begin
      iData = memDataOut;
    end
    if (dValid && !err_q) begin
      dData = memDataOut;
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (!resetn) !(iGnt && dGnt));
  a_gnt_req   : assert property (@(posedge clk) disable iff (!resetn)
                                 (!iGnt || iReq) && (!dGnt || dReq));

endmodule
